// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for memory bus initiators
package bus_pkg;

  // Transfer mode requested at start
  typedef enum logic [1:0] {
    COPY  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    RSVD  = 2'd3
  } dma_mode_t;

  // One bus access per cycle: RD and WR each own the bus for one cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_t;

  localparam logic [3:0] MASK_NONE = 4'h0;
  localparam logic [3:0] MASK_WORD = 4'hF;

endpackage

// File: rtl/bus_dma.sv
// rtl/bus_dma.sv - word-granular copy/fill/check engine on the CPU memory bus
module bus_dma
  import bus_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      pattern,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] mismatches,
  output logic [31:0]      bus_addr,
  input  logic [31:0]      bus_data_r,
  output logic [31:0]      bus_data_w,
  output logic [3:0]       bus_mask_w
);

  dma_state_t       state;
  dma_mode_t        mode_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;

  logic [LEN_W-1:0] idx_nxt;
  logic [31:0]      idx_w;
  logic [31:0]      nxt_w;
  logic             last;
  logic             rd_miss;

  // Word offsets widened to the 32-bit address space; address sums wrap mod 2^32
  assign idx_nxt = idx + LEN_W'(1);
  assign idx_w   = 32'(idx);
  assign nxt_w   = 32'(idx_nxt);
  assign last    = (idx == len_q - LEN_W'(1));
  assign rd_miss = (bus_data_r != pat_q + idx_w);

  // Transfer sequencer: every bus output comes straight from a flop so the
  // falling-edge responder sees stable values, and reset kills writes at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mode_q     <= COPY;
      src_q      <= '0;
      dst_q      <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mismatches <= '0;
      bus_addr   <= '0;
      bus_data_w <= '0;
      bus_mask_w <= MASK_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= dma_mode_t'(mode);
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            pat_q      <= pattern;
            len_q      <= length;
            idx        <= '0;
            mismatches <= '0;
            if (length == '0 || mode == RSVD) begin
              // Nothing to move: report completion without touching the bus
              state <= FIN;
              done  <= 1'b1;
            end else if (mode == FILL) begin
              state      <= WR;
              busy       <= 1'b1;
              bus_addr   <= dst_addr;
              bus_data_w <= pattern;
              bus_mask_w <= MASK_WORD;
            end else begin
              state      <= RD;
              busy       <= 1'b1;
              bus_addr   <= src_addr;
              bus_mask_w <= MASK_NONE;
            end
          end
        end
        RD: begin
          if (mode_q == CHECK) begin
            if (rd_miss && mismatches != '1) begin
              mismatches <= mismatches + LEN_W'(1);
            end
            if (last) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx      <= idx_nxt;
              bus_addr <= src_q + nxt_w;
            end
          end else begin
            // COPY: the word just read is written back in the next cycle
            state      <= WR;
            bus_addr   <= dst_q + idx_w;
            bus_data_w <= bus_data_r;
            bus_mask_w <= MASK_WORD;
          end
        end
        WR: begin
          if (last) begin
            state      <= FIN;
            busy       <= 1'b0;
            done       <= 1'b1;
            bus_mask_w <= MASK_NONE;
          end else begin
            idx <= idx_nxt;
            if (mode_q == FILL) begin
              bus_addr   <= dst_q + nxt_w;
              bus_data_w <= pat_q + nxt_w;
            end else begin
              state      <= RD;
              bus_addr   <= src_q + nxt_w;
              bus_mask_w <= MASK_NONE;
            end
          end
        end
        FIN: begin
          // start is not looked at here; the next transfer begins from IDLE
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// tb/tb_bus_dma.sv - self-checking bench for bus_dma against a falling-edge RAM
module tb_bus_dma;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic [31:0] pattern = '0;
  logic        busy;
  logic        done;
  logic [15:0] mismatches;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_r = '0;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];

  int n_checks = 0;
  int n_pass = 0;

  bus_dma #(.LEN_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .pattern(pattern),
    .busy(busy), .done(done), .mismatches(mismatches),
    .bus_addr(bus_addr), .bus_data_r(bus_data_r), .bus_data_w(bus_data_w),
    .bus_mask_w(bus_mask_w)
  );

  always #5 clock = ~clock;

  // Block RAM responder: acts on the falling edge, 1024 words, address wraps
  always @(negedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (bus_mask_w[b]) mem[bus_addr[9:0]][8*b +: 8] <= bus_data_w[8*b +: 8];
    end
    bus_data_r <= mem[bus_addr[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference behaviour: whole transfer applied to the model memory in order
  task automatic model_apply(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] l, input logic [31:0] p, output logic [15:0] mm);
    int unsigned cnt;
    cnt = 0;
    if (m != 2'd3) begin
      for (int i = 0; i < int'(l); i++) begin
        case (m)
          2'd0: ref_mem[10'(d + 32'(i))] = ref_mem[10'(s + 32'(i))];
          2'd1: ref_mem[10'(d + 32'(i))] = p + 32'(i);
          default: if (ref_mem[10'(s + 32'(i))] != p + 32'(i)) cnt++;
        endcase
      end
    end
    mm = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
  endtask

  task automatic check_image(input string name);
    int diffs;
    int first;
    diffs = 0;
    first = -1;
    for (int k = 0; k < 1024; k++) begin
      if (mem[k] !== ref_mem[k]) begin
        diffs++;
        if (first < 0) first = k;
      end
    end
    n_checks++;
    if (diffs == 0) n_pass++;
    else $display("FAIL %s: %0d words differ, first at %0h (got %0h expected %0h)",
                  name, diffs, first, mem[first], ref_mem[first]);
  endtask

  // One transfer end to end; glitch>0 pulses a foreign start in that busy cycle,
  // fin_start raises start during the done cycle
  task automatic run_xfer(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic [31:0] p, input int glitch,
                          input bit fin_start, output int nb, output logic [15:0] mm_got);
    logic [15:0] mm_exp;
    logic [31:0] ea;
    logic [3:0]  em;
    int n_exp;
    int cyc;
    bit done_seen;
    model_apply(m, s, d, l, p, mm_exp);
    n_exp = (m == 2'd3 || l == 0) ? 0 : ((m == 2'd0) ? 2 * int'(l) : int'(l));
    @(negedge clock);
    mode = m; src_addr = s; dst_addr = d; length = l; pattern = p; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    mode = 2'($urandom); src_addr = $urandom; dst_addr = $urandom;
    length = 16'($urandom); pattern = $urandom;
    cyc = 1; nb = 0; done_seen = 0; mm_got = '0;
    while (!done_seen && cyc < 200) begin
      if (done) begin
        done_seen = 1;
      end else begin
        if (busy) begin
          case (m)
            2'd0: begin
              ea = (nb % 2 == 0) ? s + 32'(nb / 2) : d + 32'(nb / 2);
              em = (nb % 2 == 0) ? 4'h0 : 4'hF;
            end
            2'd1: begin ea = d + 32'(nb); em = 4'hF; end
            default: begin ea = s + 32'(nb); em = 4'h0; end
          endcase
          check("bus_addr", bus_addr, ea);
          check("bus_mask_w", 32'(bus_mask_w), 32'(em));
          if (m == 2'd1) check("fill_data", bus_data_w, p + 32'(nb));
          nb++;
        end
        if (glitch != 0 && cyc == glitch) begin
          start = 1'b1; mode = 2'd0; src_addr = 32'h0000_0300; dst_addr = 32'h0000_0210;
          length = 16'd5; pattern = 32'h1234;
        end else begin
          start = 1'b0;
        end
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    if (done_seen) begin
      check("busy_cycles", 32'(nb), 32'(n_exp));
      check("busy_in_done", 32'(busy), 32'd0);
      check("mask_in_done", 32'(bus_mask_w), 32'd0);
      check("mismatches", 32'(mismatches), 32'(mm_exp));
      mm_got = mismatches;
      if (fin_start) begin
        start = 1'b1; mode = 2'd1; dst_addr = 32'h0000_03F0; length = 16'd3; pattern = 32'hDEAD;
      end
      @(negedge clock);
      start = 1'b0;
      check("done_pulse_len", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      check("mismatch_hold", 32'(mismatches), 32'(mm_exp));
    end
    check_image("mem_image");
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [31:0] s;
    logic [31:0] d;
    logic [15:0] l;
    logic [31:0] p;
    int          corrupt;
    int          exp_busy;
    logic [15:0] exp_mm;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int nb;
    logic [15:0] mm;
    logic [1:0] rm;
    logic [31:0] rs, rd, rp, last_fd, last_fp;
    logic [15:0] rl;
    bit clean;

    tbl[0] = '{2'd1, 32'h0,        32'h100,       16'd4, 32'hA0, -1,     4, 16'd0};
    tbl[1] = '{2'd0, 32'h10,       32'h20,        16'd3, 32'h0,  -1,     6, 16'd0};
    tbl[2] = '{2'd2, 32'h100,      32'h0,         16'd4, 32'hA0, 'h102,  4, 16'd1};
    tbl[3] = '{2'd2, 32'h100,      32'h0,         16'd0, 32'hA0, -1,     0, 16'd0};
    tbl[4] = '{2'd1, 32'h0,        32'hFFFF_FFFF, 16'd2, 32'h7,  -1,     2, 16'd0};
    tbl[5] = '{2'd3, 32'h10,       32'h50,        16'd5, 32'h9,  -1,     0, 16'd0};

    for (int k = 0; k < 1024; k++) begin
      mem[k] = $urandom;
      ref_mem[k] = mem[k];
    end
    mem[16'h10] = 32'h11; mem[16'h11] = 32'h22; mem[16'h12] = 32'h33;
    ref_mem[16'h10] = 32'h11; ref_mem[16'h11] = 32'h22; ref_mem[16'h12] = 32'h33;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mask", 32'(bus_mask_w), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_data_w, 32'd0);
    check("rst_mm", 32'(mismatches), 32'd0);
    reset = 1'b1;

    // Directed vectors
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].corrupt >= 0) begin
        mem[tbl[v].corrupt] = 32'h0;
        ref_mem[tbl[v].corrupt] = 32'h0;
      end
      run_xfer(tbl[v].m, tbl[v].s, tbl[v].d, tbl[v].l, tbl[v].p, 0, 0, nb, mm);
      check("tbl_busy", 32'(nb), 32'(tbl[v].exp_busy));
      check("tbl_mm", 32'(mm), 32'(tbl[v].exp_mm));
    end
    check("fill_word1", mem[16'h101], 32'hA1);
    check("copy_word2", mem[16'h22], 32'h33);
    check("copy_src0", mem[16'h10], 32'h11);
    check("wrap_low", mem[0], 32'h8);

    // start while busy is ignored; start during done is ignored
    run_xfer(2'd1, 32'h0, 32'h200, 16'd4, 32'h50, 2, 0, nb, mm);
    run_xfer(2'd0, 32'h200, 32'h240, 16'd2, 32'h0, 0, 1, nb, mm);

    // Reset mid-FILL after two words
    @(negedge clock);
    mode = 2'd1; dst_addr = 32'h180; length = 16'd8; pattern = 32'h900; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_mask", 32'(bus_mask_w), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_mm", 32'(mismatches), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    clean = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (done || busy) clean = 0;
    end
    check("rst_no_done", 32'(clean), 32'd1);
    ref_mem[16'h180] = 32'h900;
    ref_mem[16'h181] = 32'h901;
    check_image("rst_two_words");
    run_xfer(2'd1, 32'h0, 32'h180, 16'd8, 32'h900, 0, 0, nb, mm);

    // Randomized transfers against the model
    last_fd = 32'h100; last_fp = 32'hA0;
    for (int r = 0; r < 40; r++) begin
      rm = 2'($urandom_range(0, 3));
      rs = 32'($urandom_range(0, 1023));
      rd = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) rd = rd | ($urandom & 32'hFFFF_FC00);
      rl = 16'($urandom_range(0, 12));
      rp = $urandom;
      if (rm == 2'd2 && $urandom_range(0, 1) == 1) begin
        rs = last_fd; rp = last_fp;
      end
      if (rm == 2'd1) begin
        last_fd = rd; last_fp = rp;
      end
      run_xfer(rm, rs, rd, rl, rp, 0, 0, nb, mm);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_dma.md
Name: bus_dma

Overview:
- Word-granular block-transfer engine and second initiator on the CPU memory bus (bus_addr / bus_data_r / bus_data_w / bus_mask_w).
- Drives the same block-RAM responder the CPU drives; that responder samples on the falling edge of clock.
- Modes:
  - COPY: move N words.
  - FILL: write an incrementing pattern.
  - CHECK: read back and count mismatches against the incrementing pattern.
- Used by bring-up and self-test code to initialise and verify memory without CPU instruction overhead.

Parameters:
LEN_W, 16, width of the transfer length and of the mismatch counter

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled on rising edge while idle
mode  in  2  0=COPY, 1=FILL, 2=CHECK, 3=reserved
src_addr  in  32  source word index (COPY, CHECK)
dst_addr  in  32  destination word index (COPY, FILL)
length  in  LEN_W  word count
pattern  in  32  base data value (FILL, CHECK)
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after the last bus access
mismatches  out  LEN_W  CHECK result; held until next accepted start
bus_addr  out  32  word index presented to responder
bus_data_r  in  32  read data, valid at the rising edge ending the read cycle
bus_data_w  out  32  write data
bus_mask_w  out  4  byte write enables; 0 = read cycle

Behaviour:
- Reset (asynchronous, while low):
  - All outputs 0: bus_addr, bus_data_w, bus_mask_w, busy, done, mismatches.
  - State IDLE.
  - mask_w must drop combinationally-free, directly from the reset flop, so an in-flight write is suppressed at the next falling edge.
- Bus timing per cycle:
  - Address and mask are driven from rising-edge flops.
  - Responder acts on the falling edge.
  - Read data is captured at the following rising edge.
  - One access per cycle; no wait states.
- Start handshake:
  - start && !busy at rising edge T0 latches mode, src_addr, dst_addr, length, pattern, and clears index i and mismatches.
  - start while busy is ignored.
  - Inputs may change after T0 without effect.
- States:
  - IDLE: bus_mask_w = 0 and bus_addr holds its last value.
  - RD: bus_addr = src+i, mask 0.
  - WR: bus_addr = dst+i, bus_data_w = data, mask 4'hF.
  - FIN: done = 1, busy = 0, then IDLE.
- COPY: RD -> WR per word.
  - Data captured from bus_data_r at the end of RD.
  - 2*length access cycles.
- FILL: WR only. Data = pattern + i (mod 2^32). length access cycles.
- CHECK: RD only.
  - At the end of each RD, compare bus_data_r with pattern + i.
  - On inequality, mismatches increments, saturating at all-ones.
  - length access cycles.
- busy = 1 from the cycle after T0 through the last access cycle. done pulses for exactly the one cycle following it.
- length = 0 or mode = 3: no bus access (mask stays 0); done pulses in the cycle after T0; busy never asserts.
- Address arithmetic is modulo 2^32 (wrap from 0xFFFFFFFF to 0). i counts 0..length-1 in LEN_W bits.
- Overlapping src/dst in COPY: strict ascending order, one word at a time. No overlap correction.
- start asserted in the FIN cycle is ignored. A new transfer may start from the cycle after done.
- Reset mid-transfer: abort immediately, no done pulse, mismatches cleared.

Decomposition:
- Shared package bus_pkg:
  - dma_mode_t enum (COPY, FILL, CHECK, RSVD).
  - dma_state_t enum (IDLE, RD, WR, FIN).
  - Constants MASK_NONE = 4'h0, MASK_WORD = 4'hF.
  - Reusable by the CPU and any future bus initiators/arbiter.
- No sub-module; a single flat FSM with the index counter is natural.

Test Plan:
- Bench setup: bus_dma against a falling-edge 1024-word RAM model.
- FILL: dst=0x100, len=4, pattern=0xA0 -> mem[0x100..0x103] = A0,A1,A2,A3; busy for 4 cycles; done one cycle later; mismatches = 0.
- COPY: preload mem[0x10..0x12] = 11,22,33; src=0x10, dst=0x20, len=3 -> mem[0x20..0x22] = 11,22,33; 6 access cycles with mask alternating 0/F; source unchanged.
- CHECK: after the FILL above, corrupt mem[0x102] = 0; src=0x100, len=4, pattern=0xA0 -> mismatches = 1; second start with len=0 -> done next cycle, no access, mismatches = 0.
- Edge cases:
  - FILL with dst=0xFFFFFFFF, len=2 -> addresses 0xFFFFFFFF then 0x0.
  - start pulsed during busy -> ignored; original transfer completes unchanged.
- Reset low for 1 cycle mid-FILL (after 2 of 8 words) -> bus_mask_w = 0 before the next falling edge; exactly 2 words written; busy = 0; no done pulse; a new FILL afterwards completes normally.
